// File: rtl/stream_pkg.sv
// Shared helpers for stream_merge: channel-index width and the round-robin requester search.
package stream_pkg;

  localparam int MAX_IN   = 8;
  localparam int MAX_CH_W = 3;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {found, index} of the first set bit of req after ptr, in cyclic order over n channels.
  function automatic logic [MAX_CH_W:0] rr_pick(input logic [MAX_IN-1:0] req, input int ptr,
                                                input int n);
    logic [MAX_CH_W:0]   res;
    logic [MAX_CH_W-1:0] sel;
    int                  idx;
    res = '0;
    for (int k = MAX_IN; k >= 1; k--) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        sel = idx[MAX_CH_W-1:0];
        if (req[sel]) res = {1'b1, sel};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel circular-buffer FIFO with registered occupancy; head is presented combinationally.
module stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // Storage is not reset: pointer reset already makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/stream_merge.sv
// N-to-1 ready/valid byte merger: private FIFO per input, round-robin drain into one output register.
// A byte accepted into an empty FIFO at edge t is presented on out_valid after edge t+1.
module stream_merge
  import stream_pkg::*;
#(
  parameter  int NUM_IN = 2,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  parameter  int CH_W   = ch_width(NUM_IN),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_enable,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_byte,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_byte,
  output logic [CH_W-1:0]         out_channel,
  output logic [NUM_IN*LW-1:0]    fifo_level
);

  logic [NUM_IN-1:0] full;
  logic [NUM_IN-1:0] empty;
  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic [WIDTH-1:0]  head [NUM_IN];

  logic [MAX_IN-1:0] req;
  logic [MAX_CH_W:0] pick;
  logic              load;
  logic              grant;
  logic [CH_W-1:0]   grant_ch;

  logic              vld_p0;
  logic [WIDTH-1:0]  byte_p0;
  logic [CH_W-1:0]   ch_p0;
  logic [CH_W-1:0]   rr_ptr;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    // Muted channels always accept and drop; ready never looks at valid.
    assign in_ready[i] = !reset && (!in_enable[i] || !full[i]);
    assign push[i]     = in_valid[i] && in_ready[i] && in_enable[i];

    stream_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push[i]),
      .wr_data(in_byte[i*WIDTH +: WIDTH]),
      .pop    (pop[i]),
      .rd_data(head[i]),
      .full   (full[i]),
      .empty  (empty[i]),
      .level  (fifo_level[i*LW +: LW])
    );
  end

  always_comb begin
    req               = '0;
    req[NUM_IN-1:0]   = ~empty;
    pick              = rr_pick(req, int'(rr_ptr), NUM_IN);
    load              = !vld_p0 || out_ready;
    grant             = load && pick[MAX_CH_W];
    grant_ch          = CH_W'(pick[MAX_CH_W-1:0]);
    pop               = '0;
    if (grant) pop[grant_ch] = 1'b1;
  end

  // Stage p0: output register, refilled whenever empty or consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      byte_p0 <= '0;
      ch_p0   <= '0;
      rr_ptr  <= CH_W'(NUM_IN - 1);
    end else if (load) begin
      vld_p0 <= grant;
      if (grant) begin
        byte_p0 <= head[grant_ch];
        ch_p0   <= grant_ch;
        rr_ptr  <= grant_ch;
      end
    end
  end

  assign out_valid   = vld_p0;
  assign out_byte    = byte_p0;
  assign out_channel = ch_p0;

endmodule
